// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 decoder: buffers 3-bit codes in a small FIFO and replays each
// one as a registered one-hot word held on out for HOLD enabled cycles.
module decoder_3x8_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          en,
    output logic [7:0]    out,
    output logic          out_valid,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    out_q, out_d;
    logic          out_valid_q, out_valid_d;

    logic          push;
    logic          pop;
    logic [2:0]    head;

    // in_ready depends on registered occupancy only, never on this cycle's pop.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign busy      = (state_q == ACTIVE) || (count_q != '0);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                out_d       = '0;
                out_valid_d = 1'b0;
                if (en && (count_q != '0)) begin
                    pop         = 1'b1;
                    out_d       = 8'(1) << head;
                    out_valid_d = 1'b1;
                    hold_d      = HOLD_INIT;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (en) begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HW'(1);
                    end else if (count_q != '0) begin
                        pop    = 1'b1;
                        out_d  = 8'(1) << head;
                        hold_d = HOLD_INIT;
                    end else begin
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_d       = '0;
                out_valid_d = 1'b0;
                hold_d      = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Directed self-checking bench for decoder_3x8_seq (DEPTH=4, HOLD=4).
module tb_decoder_3x8_seq;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [2:0]    in_code;
    logic          in_valid;
    logic          in_ready;
    logic          en;
    logic [7:0]    out;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] count;

    int unsigned n_checks;
    int unsigned n_fail;

    decoder_3x8_seq #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it; all checks sample here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned sent;
        int unsigned widx;
        int unsigned run;
        int unsigned exp_cnt;
        logic        pre_ready;
        logic        pre_ov;
        logic [7:0]  pre_out;
        logic [CW-1:0] pre_count;
        logic        pushed;
        logic        popped;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_code  = '0;
        in_valid = 1'b0;
        en       = 1'b0;

        // 1: reset values, during and after reset
        tick();
        tick();
        check("rst_out", 32'(out), 32'h00);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_out", 32'(out), 32'h00);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 2: single code 5 held exactly HOLD cycles
        en       = 1'b1;
        in_code  = 3'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t2_count_after_push", 32'(count), 32'd1);
        check("t2_out_before_pop", 32'(out), 32'h00);
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check("t2_out_hold", 32'(out), 32'h20);
            check("t2_out_valid_hold", 32'(out_valid), 32'd1);
        end
        tick();
        check("t2_out_end", 32'(out), 32'h00);
        check("t2_out_valid_end", 32'(out_valid), 32'd0);
        check("t2_busy_end", 32'(busy), 32'd0);

        // 3: fill while paused, refuse a fifth code, then replay back-to-back
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_code  = 3'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t3_count_full", 32'(count), 32'd4);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        check("t3_out_paused", 32'(out), 32'h00);
        in_code  = 3'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_count_refused", 32'(count), 32'd4);
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < HOLD; i++) begin
                tick();
                check("t3_replay", 32'(out), 32'(8'h01 << c));
            end
        end
        tick();
        check("t3_out_end", 32'(out), 32'h00);
        check("t3_count_end", 32'(count), 32'd0);
        check("t3_out_valid_end", 32'(out_valid), 32'd0);

        // 4: stream 7..0 with in_valid held whenever codes remain
        sent    = 0;
        widx    = 0;
        run     = 0;
        exp_cnt = 0;
        in_code = 3'd7;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            pre_ready = in_ready;
            pre_count = count;
            pre_out   = out;
            pre_ov    = out_valid;
            tick();
            pushed = in_valid && pre_ready;
            popped = out_valid && (!pre_ov || (out != pre_out));
            if (pushed) begin
                sent++;
                if (sent < 8) in_code = 3'(7 - sent);
                else in_valid = 1'b0;
            end
            exp_cnt = 32'(pre_count) + (pushed ? 1 : 0) - (popped ? 1 : 0);
            check("t4_count", 32'(count), exp_cnt);
            check("t4_in_ready", 32'(in_ready), 32'(count < CW'(DEPTH)));
            if (popped) begin
                if (widx != 0) check("t4_run_len", run, HOLD);
                check("t4_word", 32'(out), 32'(8'h80 >> widx));
                widx++;
                run = 1;
            end else if (out_valid) begin
                run++;
            end else if (pre_ov) begin
                check("t4_run_len_last", run, HOLD);
            end
            if (sent == 8 && !out_valid && !busy && widx != 0) break;
        end
        check("t4_words_seen", widx, 32'd8);
        check("t4_codes_sent", sent, 32'd8);
        check("t4_idle_end", 32'(busy), 32'd0);

        // 5: pause mid-hold of code 2 for 3 cycles; word shown 7 cycles in total
        in_code  = 3'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run = 0;
        for (int c = 0; c < 12; c++) begin
            en = !(c >= 2 && c < 5);
            tick();
            if (out_valid && out == 8'h04) run++;
        end
        en = 1'b1;
        check("t5_pause_run", run, 32'd7);
        check("t5_out_end", 32'(out), 32'h00);

        // 6: asynchronous reset mid-burst discards buffered codes
        in_valid = 1'b1;
        in_code  = 3'd4;
        tick();
        in_code  = 3'd1;
        tick();
        in_code  = 3'd2;
        tick();
        in_code  = 3'd3;
        tick();
        in_valid = 1'b0;
        check("t6_count_pre", 32'(count), 32'd3);
        check("t6_out_pre", 32'(out), 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_out", 32'(out), 32'h00);
        check("t6_async_count", 32'(count), 32'd0);
        check("t6_async_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_no_stale", 32'({out_valid, out}), 32'h000);
        end
        check("t6_count_end", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
